// File: rtl/jedro_1_ifu_pkg.sv
// Shared definitions for the jedro_1 instruction fetch path.
package jedro_1_ifu_pkg;

  // PC value after reset unless the instance overrides it
  localparam logic [31:0] IFU_BOOT_ADDR = 32'h0000_0000;

  // Canonical no-op (addi x0, x0, 0)
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Default prefetch depth
  localparam int unsigned IFU_DEPTH = 32'd4;

  // One fetched word together with the byte address it came from
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/jedro_1_ifu_if.sv
// Fetch-unit bus bundle: instruction memory read port plus decoder handshake.
// The "master" side is the fetch unit, the "slave" side is memory and decoder.
interface jedro_1_ifu_if #(
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned ADDR_WIDTH = 32'd32
);
  logic                  imem_en_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;
  logic                  instr_valid_o;
  logic                  decoder_ready_i;
  logic                  jmp_instr_i;
  logic [ADDR_WIDTH-1:0] jmp_addr_i;

  modport master (
    output imem_en_o, imem_addr_o, instr_o, instr_addr_o, instr_valid_o,
    input  imem_rdata_i, decoder_ready_i, jmp_instr_i, jmp_addr_i
  );

  modport slave (
    input  imem_en_o, imem_addr_o, instr_o, instr_addr_o, instr_valid_o,
    output imem_rdata_i, decoder_ready_i, jmp_instr_i, jmp_addr_i
  );
endinterface

// File: rtl/jedro_1_ifu_sfifo.sv
// Generic synchronous FIFO with flush. DEPTH must be a power of two >= 2 so
// the pointers wrap naturally. Flush has priority over push and pop.
module jedro_1_ifu_sfifo #(
  parameter int unsigned DEPTH   = 32'd4,
  parameter type         entry_t = logic [63:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   wdata,
  output entry_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests: never pop when empty, never push into a full FIFO
  // unless the same cycle frees a slot
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != FULL_COUNT) || do_pop_s);
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates their use
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == FULL_COUNT);
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: keeps the PC, issues one ROM read per cycle
// while the prefetch FIFO plus the in-flight read have room, and presents the
// FIFO head to the decoder. A redirect flushes the FIFO, kills the in-flight
// read and reloads the PC with the word-aligned target.
module jedro_1_ifu
  import jedro_1_ifu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32'd32,
  parameter int unsigned           ADDR_WIDTH = 32'd32,
  parameter int unsigned           DEPTH      = IFU_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(IFU_BOOT_ADDR)
) (
  input logic              clk_i,
  input logic              rstn_i,
  jedro_1_ifu_if.master    bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] last_instr_r;
  logic [ADDR_WIDTH-1:0] last_addr_r;

  logic [CW-1:0]         count_s;
  logic [CW:0]           occupancy_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic [ADDR_WIDTH-1:0] jmp_target_s;
  entry_t                head_s;
  entry_t                push_entry_s;

  // Issue/push/pop decisions. Slots already promised (FIFO entries plus the
  // read in flight) minus this cycle's pop must leave room for a new read.
  // A redirect suppresses both the issue and the push of the killed read.
  always_comb begin
    pop_s              = !empty_s && bus.decoder_ready_i;
    occupancy_s        = {1'b0, count_s} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
    issue_s            = !bus.jmp_instr_i && (occupancy_s < (CW+1)'(DEPTH));
    push_s             = inflight_r && !bus.jmp_instr_i && (!full_s || pop_s);
    jmp_target_s       = {bus.jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
    push_entry_s.instr = bus.imem_rdata_i;
    push_entry_s.addr  = rd_addr_r;
  end

  // PC and in-flight tracking; redirect takes priority over sequential fetch
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_r       <= BOOT_ADDR;
      rd_addr_r  <= BOOT_ADDR;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) rd_addr_r <= pc_r;
      if (bus.jmp_instr_i) begin
        pc_r <= jmp_target_s;
      end else if (issue_s) begin
        pc_r <= pc_r + ADDR_WIDTH'(32'd4);
      end
    end
  end

  // Remember the most recently presented head so the outputs hold when empty
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_instr_r <= '0;
      last_addr_r  <= '0;
    end else if (!empty_s) begin
      last_instr_r <= head_s.instr;
      last_addr_r  <= head_s.addr;
    end
  end

  jedro_1_ifu_sfifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_prefetch (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.jmp_instr_i),
    .wdata (push_entry_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // The read strobe is gated by reset so it drops the moment reset asserts
  assign bus.imem_en_o     = issue_s && rstn_i;
  assign bus.imem_addr_o   = pc_r;
  assign bus.instr_valid_o = !empty_s;
  assign bus.instr_o       = empty_s ? last_instr_r : head_s.instr;
  assign bus.instr_addr_o  = empty_s ? last_addr_r  : head_s.addr;

endmodule
